mc_ctrl_fsm: RTL and testbench

MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

---
 rtl/mc_ctrl_fsm.sv | 158 +++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle CPU control FSM with retired-instruction counter
module mc_ctrl_fsm #(
    parameter int MEMWAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic        memready,
    output logic        memreq,
    output logic        iord,
    output logic        irwrite,
    output logic        pcwrite,
    output logic        branch,
    output logic        memwrite,
    output logic        regwrite,
    output logic        memtoreg,
    output logic        regdst,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsrc,
    output logic [1:0]  aluop,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] instret
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                           OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

    state_t state_q, state_d;
    logic   rdy, retire;

    assign state = state_q;

    // state register; reset forces FETCH immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // retired-instruction counter, wraps naturally at 32 bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      instret <= '0;
        else if (retire) instret <= instret + 32'd1;
    end

    // next state and per-state datapath controls; memready only sampled where a memory access is pending
    always_comb begin
        state_d  = FETCH;
        retire   = 1'b0;
        rdy      = 1'b0;
        memreq   = 1'b0;
        iord     = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 2'b00;
        illegal  = 1'b0;
        case (state_q)
            FETCH: begin
                rdy     = (MEMWAIT == 0) || memready;
                memreq  = 1'b1;
                alusrcb = 2'b01;
                irwrite = rdy;
                pcwrite = rdy;
                state_d = rdy ? DECODE : FETCH;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    default:      illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                rdy     = (MEMWAIT == 0) || memready;
                memreq  = 1'b1;
                iord    = 1'b1;
                state_d = rdy ? MEMWB : MEMRD;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                retire   = 1'b1;
            end
            MEMWR: begin
                rdy      = (MEMWAIT == 0) || memready;
                memreq   = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
                retire   = rdy;
                state_d  = rdy ? FETCH : MEMWR;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = RTYPEWB;
            end
            RTYPEWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                retire   = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                retire  = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
            end
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                retire  = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed-vector bench for the multicycle control FSM
module tb_mc_ctrl_fsm;
    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic        memready;
    logic        memreq, iord, irwrite, pcwrite, branch, memwrite;
    logic        regwrite, memtoreg, regdst, alusrca, illegal;
    logic [1:0]  alusrcb, pcsrc, aluop;
    logic [3:0]  state;
    logic [31:0] instret;
    int          checks = 0;
    int          failures = 0;

    mc_ctrl_fsm #(.MEMWAIT(1)) dut (
        .clk(clk), .reset(reset), .op(op), .memready(memready),
        .memreq(memreq), .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite),
        .branch(branch), .memwrite(memwrite), .regwrite(regwrite),
        .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .illegal(illegal),
        .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; op = 6'b100011; memready = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_instret", instret, 0);
        check("rst_illegal", 32'(illegal), 0);
        check("rst_memreq", 32'(memreq), 1);
        check("rst_alusrcb", 32'(alusrcb), 1);
        check("rst_irwrite_lo", 32'(irwrite), 0);
        memready = 1'b1;
        #1;
        check("rst_irwrite_hi", 32'(irwrite), 1);
        check("rst_pcwrite_hi", 32'(pcwrite), 1);
        memready = 1'b0;
        @(negedge clk) reset = 1'b1;
        // fetch stall, then lw with memory always ready
        for (int i = 0; i < 2; i++) begin
            tick();
            check("fetch_hold_state", 32'(state), 0);
            check("fetch_hold_irwrite", 32'(irwrite), 0);
            check("fetch_hold_pcwrite", 32'(pcwrite), 0);
        end
        memready = 1'b1;
        #1;
        check("fetch_ready_irwrite", 32'(irwrite), 1);
        tick();
        check("lw_decode", 32'(state), 1);
        check("decode_alusrcb", 32'(alusrcb), 3);
        tick();
        check("lw_memadr", 32'(state), 2);
        check("memadr_alusrca", 32'(alusrca), 1);
        check("memadr_alusrcb", 32'(alusrcb), 2);
        tick();
        check("lw_memrd", 32'(state), 3);
        check("memrd_iord", 32'(iord), 1);
        check("memrd_memreq", 32'(memreq), 1);
        tick();
        check("lw_memwb", 32'(state), 4);
        check("memwb_regwrite", 32'(regwrite), 1);
        check("memwb_memtoreg", 32'(memtoreg), 1);
        check("lw_instret_pre", instret, 0);
        tick();
        check("lw_fetch", 32'(state), 0);
        check("lw_instret", instret, 1);
        // sw with memory stalled for three cycles in MEMWR
        op = 6'b101011;
        tick();
        check("sw_decode", 32'(state), 1);
        tick();
        check("sw_memadr", 32'(state), 2);
        memready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sw_memwr_wait", 32'(state), 5);
            check("sw_memwrite_wait", 32'(memwrite), 1);
        end
        check("sw_instret_hold", instret, 1);
        memready = 1'b1;
        #1;
        check("sw_memwrite_last", 32'(memwrite), 1);
        tick();
        check("sw_fetch", 32'(state), 0);
        check("sw_instret", instret, 2);
        // illegal opcode
        op = 6'b111111;
        tick();
        check("ill_decode", 32'(state), 1);
        check("ill_pulse", 32'(illegal), 1);
        tick();
        check("ill_fetch", 32'(state), 0);
        check("ill_clear", 32'(illegal), 0);
        check("ill_instret", instret, 2);
        // beq
        op = 6'b000100;
        tick();
        tick();
        check("beq_state", 32'(state), 8);
        check("beq_pcsrc", 32'(pcsrc), 1);
        check("beq_aluop", 32'(aluop), 1);
        check("beq_branch", 32'(branch), 1);
        check("beq_pcwrite", 32'(pcwrite), 0);
        tick();
        check("beq_instret", instret, 3);
        // j
        op = 6'b000010;
        tick();
        tick();
        check("j_state", 32'(state), 11);
        check("j_pcsrc", 32'(pcsrc), 2);
        check("j_pcwrite", 32'(pcwrite), 1);
        tick();
        check("j_instret", instret, 4);
        // addi
        op = 6'b001000;
        tick();
        tick();
        check("addi_ex", 32'(state), 9);
        check("addi_alusrcb", 32'(alusrcb), 2);
        tick();
        check("addi_wb", 32'(state), 10);
        check("addi_regwrite", 32'(regwrite), 1);
        check("addi_regdst", 32'(regdst), 0);
        tick();
        check("addi_instret", instret, 5);
        // full r-type
        op = 6'b000000;
        tick();
        tick();
        check("r_ex", 32'(state), 6);
        check("r_aluop", 32'(aluop), 2);
        tick();
        check("r_wb", 32'(state), 7);
        check("r_regdst", 32'(regdst), 1);
        tick();
        check("r_instret", instret, 6);
        // asynchronous reset in the middle of RTYPEEX
        tick();
        tick();
        check("rr_ex", 32'(state), 6);
        #2 reset = 1'b0;
        #1;
        check("async_state", 32'(state), 0);
        check("async_instret", instret, 0);
        check("async_illegal", 32'(illegal), 0);
        @(negedge clk) reset = 1'b1;
        tick();
        check("post_reset_decode", 32'(state), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
